// File: rtl/vlc_bit_packer.sv
// ---------------------------------------------------------------------------
// vlc_bit_packer
//   Packs variable-length codes MSB-first into 32-bit words for the slice
//   bitstream writer. Each accepted code is appended to a left-justified
//   64-bit accumulator. A full word is emitted whenever 32 or more bits are
//   pending. A flush pads the final partial word with zeros.
//   No backpressure is needed: at most one word is produced per accepted code.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   in_enable   code valid this cycle
//   in_val      code bits, right-aligned (bits at/above in_size ignored)
//   in_size     code length 0..MAX_CODE; larger codes are dropped and flag error
//   in_flush    pad to a word boundary after this cycle's code
//   busy        high during the one-cycle FLUSH_TAIL state; inputs are dropped
//   out_valid   one-cycle pulse per packed word
//   out_data    packed word, first stream bit at bit 31 (zero when not valid)
//   flush_done  pulse when the last word of a flush has been issued
//   word_count  words emitted since reset (wraps)
//   error       sticky: oversize code, or input presented while busy
// ---------------------------------------------------------------------------
module vlc_bit_packer #(
    parameter int OUT_W    = 32,
    parameter int ACC_W    = 64,
    parameter int MAX_CODE = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_enable,
    input  logic [ACC_W-1:0] in_val,
    input  logic [63:0]      in_size,
    input  logic             in_flush,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             flush_done,
    output logic [31:0]      word_count,
    output logic             error
);

    localparam int FW = $clog2(ACC_W) + 1;  // holds 0..ACC_W inclusive

    typedef enum logic {RUN, FLUSH_TAIL} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc;
    logic [FW-1:0]    fill;

    logic             size_ok;
    logic             take;
    logic [FW-1:0]    add;
    logic [ACC_W-1:0] code_mask;
    logic [FW-1:0]    shamt;
    logic [ACC_W-1:0] acc_n;
    logic [FW-1:0]    fill_n;

    // Append datapath. fill < OUT_W in RUN, so fill+add <= 63 and the
    // placement shift is always >= 1. When fill=add=0 the shift is ACC_W,
    // which yields zero, matching the empty code.
    assign size_ok   = (in_size <= 64'(MAX_CODE));
    assign take      = (state == RUN) && in_enable && size_ok;
    assign add       = take ? in_size[FW-1:0] : '0;
    assign code_mask = (ACC_W'(1) << add) - ACC_W'(1);
    assign shamt     = FW'(ACC_W) - fill - add;
    assign acc_n     = acc | ((in_val & code_mask) << shamt);
    assign fill_n    = fill + add;

    assign busy = (state == FLUSH_TAIL);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_n;
    end

    // Next state: a flush leaving more than one word's worth of bits needs
    // one extra cycle to issue the padded remainder.
    always_comb begin
        state_n = state;
        case (state)
            RUN:        if (in_flush && (fill_n > FW'(OUT_W))) state_n = FLUSH_TAIL;
            FLUSH_TAIL: state_n = RUN;
            default:    state_n = RUN;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            flush_done <= 1'b0;
            word_count <= '0;
            error      <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (in_enable && !size_ok) error <= 1'b1;
                    if (in_flush) begin
                        if (fill_n == '0) begin
                            flush_done <= 1'b1;
                            acc        <= '0;
                            fill       <= '0;
                        end else if (fill_n <= FW'(OUT_W)) begin
                            // Bits below fill_n are already zero: the word is padded.
                            out_valid  <= 1'b1;
                            out_data   <= acc_n[ACC_W-1 -: OUT_W];
                            flush_done <= 1'b1;
                            word_count <= word_count + 32'd1;
                            acc        <= '0;
                            fill       <= '0;
                        end else begin
                            // Full word now, padded remainder from FLUSH_TAIL.
                            out_valid  <= 1'b1;
                            out_data   <= acc_n[ACC_W-1 -: OUT_W];
                            word_count <= word_count + 32'd1;
                            acc        <= acc_n << OUT_W;
                            fill       <= fill_n - FW'(OUT_W);
                        end
                    end else if (fill_n >= FW'(OUT_W)) begin
                        out_valid  <= 1'b1;
                        out_data   <= acc_n[ACC_W-1 -: OUT_W];
                        word_count <= word_count + 32'd1;
                        acc        <= acc_n << OUT_W;
                        fill       <= fill_n - FW'(OUT_W);
                    end else begin
                        acc  <= acc_n;
                        fill <= fill_n;
                    end
                end
                FLUSH_TAIL: begin
                    if (in_enable || in_flush) error <= 1'b1;
                    out_valid  <= 1'b1;
                    out_data   <= acc[ACC_W-1 -: OUT_W];
                    flush_done <= 1'b1;
                    word_count <= word_count + 32'd1;
                    acc        <= '0;
                    fill       <= '0;
                end
                default: begin
                    acc  <= '0;
                    fill <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// ---------------------------------------------------------------------------
// tb_vlc_bit_packer
//   Scoreboard bench. The reference model keeps the pending stream as a queue
//   of bits; words are cut from its head, flushes pad it to 32-bit multiples.
//   Expected output events are queued at stimulus time and popped by an
//   independent monitor whenever out_valid or flush_done is seen.
// ---------------------------------------------------------------------------
module tb_vlc_bit_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_enable;
    logic [63:0] in_val;
    logic [63:0] in_size;
    logic        in_flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_data;
    logic        flush_done;
    logic [31:0] word_count;
    logic        error;

    vlc_bit_packer dut (
        .clock      (clock),
        .reset      (reset),
        .in_enable  (in_enable),
        .in_val     (in_val),
        .in_size    (in_size),
        .in_flush   (in_flush),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .flush_done (flush_done),
        .word_count (word_count),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          valid;
        bit [31:0]   data;
        bit          fd;
        int unsigned wc;
    } exp_t;

    exp_t        expq[$];
    bit          bq[$];        // pending stream bits, oldest first
    bit          busy_m;
    bit          err_m;
    int unsigned wc_m;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void emit_word(input bit fd);
        exp_t e;
        e.data = '0;
        for (int i = 31; i >= 0; i--) e.data[i] = bq.pop_front();
        wc_m++;
        e.valid = 1'b1;
        e.fd    = fd;
        e.wc    = wc_m;
        expq.push_back(e);
    endfunction

    function automatic void model_step(input bit en, input logic [63:0] val,
                                       input logic [63:0] size, input bit fl);
        exp_t e;
        if (busy_m) begin
            if (en || fl) err_m = 1'b1;
            busy_m = 1'b0;
            return;
        end
        if (en) begin
            if (size > 64'd32) err_m = 1'b1;
            else for (int i = int'(size) - 1; i >= 0; i--) bq.push_back(val[i]);
        end
        if (fl) begin
            if (bq.size() == 0) begin
                e.valid = 1'b0; e.data = '0; e.fd = 1'b1; e.wc = wc_m;
                expq.push_back(e);
            end else if (bq.size() <= 32) begin
                while (bq.size() % 32 != 0) bq.push_back(1'b0);
                emit_word(1'b1);
            end else begin
                emit_word(1'b0);
                while (bq.size() % 32 != 0) bq.push_back(1'b0);
                emit_word(1'b1);
                busy_m = 1'b1;
            end
        end else if (bq.size() >= 32) begin
            emit_word(1'b0);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit en, input logic [63:0] val, input logic [63:0] size, input bit fl);
        @(negedge clock);
        chk("busy", busy, busy_m);
        chk("error", error, err_m);
        in_enable = en;
        in_val    = val;
        in_size   = size;
        in_flush  = fl;
        model_step(en, val, size, fl);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_enable = 1'b0; in_flush = 1'b0; in_val = '0; in_size = '0;
        bq.delete(); expq.delete(); busy_m = 1'b0; err_m = 1'b0; wc_m = 0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                if (!out_valid) chk("idle_data_zero", out_data, 0);
                if (out_valid || flush_done) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_output", {out_valid, flush_done}, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("out_valid", out_valid, e.valid);
                        chk("out_data", out_data, e.data);
                        chk("flush_done", flush_done, e.fd);
                        chk("word_count", word_count, e.wc);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; in_enable = 1'b0; in_val = '0; in_size = '0; in_flush = 1'b0;
        busy_m = 1'b0; err_m = 1'b0; wc_m = 0;
        do_reset();

        // mid-stream reset: leftover bits must not leak into the next word
        step(1, 64'h3FF, 10, 0);
        step(1, 64'h1, 3, 0);
        do_reset();

        // four bytes make one word
        step(1, 64'hA1, 8, 0);
        step(1, 64'hB2, 8, 0);
        step(1, 64'hC3, 8, 0);
        step(1, 64'hD4, 8, 0);
        @(posedge clock); #1;
        chk("t2_latency_valid", out_valid, 1);
        chk("t2_word", out_data, 32'hA1B2C3D4);
        chk("t2_count", word_count, 1);
        step(0, 0, 0, 0);

        // one word per cycle, no gaps; upper junk bits of in_val ignored
        step(1, 64'hDEAD_0000_FFFF, 16, 0);
        for (int i = 0; i < 6; i++) step(1, 64'hFFFF_FFFF_1234_5678, 32, 0);
        step(0, 0, 0, 1);

        // short code with flush -> padded word
        step(1, 64'h16, 5, 1);
        @(posedge clock); #1;
        chk("t4_word", out_data, 32'hB000_0000);
        chk("t4_flush_done", flush_done, 1);
        step(0, 0, 0, 0);

        // flush above a word boundary -> full word, busy cycle, padded tail
        step(1, 64'h12345, 20, 0);
        step(1, 64'hABCDE, 20, 1);
        step(1, 64'hFF, 8, 0);       // dropped while busy
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // oversize code leaves fill alone; empty flush
        do_reset();
        step(1, 64'h5, 3, 0);
        step(1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        step(1, 64'h0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 64'h0, 0, 1);
        step(0, 0, 0, 0);

        // randomized segments
        for (int seg = 0; seg < 3; seg++) begin
            do_reset();
            for (int n = 0; n < 400; n++) begin
                logic [63:0] v;
                logic [63:0] s;
                v = {$urandom, $urandom};
                s = ($urandom_range(0, 19) == 0) ? 64'($urandom_range(33, 70))
                                                 : 64'($urandom_range(0, 32));
                step($urandom_range(0, 3) != 0, v, s, $urandom_range(0, 7) == 0);
            end
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
            chk("drained", expq.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
